// File: rtl/packet_rr_mux_arbiter.sv
// Packet-aware round-robin arbiter that steers one of N_REQ valid/ready
// producers into a single registered output stage.
//
// Handshakes use strict valid/ready semantics. A beat moves when valid and
// ready are both high at a rising clock edge. A producer must hold its valid
// and beat stable until it is accepted. in_ready never depends on in_data or
// in_last. The output register can take a new beat in the same cycle that
// downstream pops the old one.
module packet_rr_mux_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8,
    localparam int IDW = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       in_valid,
    input  logic [N_REQ-1:0]       in_last,
    input  logic [N_REQ*WIDTH-1:0] in_data,
    output logic [N_REQ-1:0]       in_ready,
    output logic                   out_valid,
    output logic                   out_last,
    output logic [WIDTH-1:0]       out_data,
    input  logic                   out_ready,
    output logic [IDW-1:0]         grant_id,
    output logic                   busy
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t           state, state_next;
    logic [IDW-1:0]   ptr;
    logic [IDW-1:0]   win;
    logic [IDW-1:0]   sel;
    logic             any_valid;
    logic             slot;
    logic             acc;
    logic [WIDTH-1:0] data_arr [N_REQ];

    // Split the flat data bus into one lane per requester.
    for (genvar i = 0; i < N_REQ; i++) begin : g_lane
        assign data_arr[i] = in_data[i*WIDTH +: WIDTH];
    end

    // Round-robin search: first valid requester after ptr, wrapping.
    // Scanning from the far end lets the nearest candidate overwrite the rest.
    always_comb begin : win_search
        int idx;
        idx       = 0;
        win       = '0;
        any_valid = 1'b0;
        for (int k = N_REQ; k >= 1; k--) begin
            idx = (int'(ptr) + k) % N_REQ;
            if (in_valid[idx[IDW-1:0]]) begin
                win       = idx[IDW-1:0];
                any_valid = 1'b1;
            end
        end
    end

    assign sel  = (state == LOCKED) ? grant_id : win;
    assign slot = !out_valid || out_ready;
    assign acc  = in_valid[sel] && in_ready[sel];
    assign busy = (state == LOCKED);

    // Ready goes only to the selected requester, and only while the output slot is free.
    always_comb begin
        in_ready = '0;
        if (!rst && (state == LOCKED || any_valid)) begin
            in_ready[sel] = slot;
        end
    end

    // Next-state logic: lock on a multi-beat first beat, release on the last beat.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (acc && !in_last[win]) begin
                    state_next = LOCKED;
                end
            end
            LOCKED: begin
                if (acc && in_last[grant_id]) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Owner tracking. The pointer moves only when a packet finishes.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_id <= '0;
            ptr      <= IDW'(N_REQ - 1);
        end else if (acc) begin
            grant_id <= sel;
            if (in_last[sel]) begin
                ptr <= sel;
            end
        end
    end

    // One-entry output register. A new beat replaces a popped one with no bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else if (acc) begin
            out_valid <= 1'b1;
            out_last  <= in_last[sel];
            out_data  <= data_arr[sel];
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_packet_rr_mux_arbiter.sv
// Self-checking bench for packet_rr_mux_arbiter: directed scenarios followed
// by randomized traffic, all compared against a rule-level reference model.
module tb_packet_rr_mux_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  typedef struct packed {
    logic         last;
    logic [W-1:0] data;
  } beat_t;

  // ---------------- clock / reset / DUT ----------------
  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_last;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_ready;
  logic           out_valid;
  logic           out_last;
  logic [W-1:0]   out_data;
  logic           out_ready;
  logic [1:0]     grant_id;
  logic           busy;

  always #5 clk = ~clk;

  packet_rr_mux_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_last(in_last), .in_data(in_data),
    .in_ready(in_ready),
    .out_valid(out_valid), .out_last(out_last), .out_data(out_data),
    .out_ready(out_ready),
    .grant_id(grant_id), .busy(busy)
  );

  // ---------------- bench state ----------------
  int checks = 0;
  int errors = 0;

  beat_t        src_q [N][$];   // pending beats per producer
  logic [N-1:0] hold;           // producer-side valid gaps
  beat_t        exp_q [$];      // scoreboard: accepted beats awaiting output
  beat_t        out_log [$];    // beats seen leaving the DUT
  beat_t        want_log [$];   // directed expectation for out_log
  logic [N-1:0] last_ready;     // in_ready seen during the latest step

  // Reference model: owner (-1 when nobody holds a packet), rotating pointer,
  // most recent owner, and the one-entry output register.
  int           m_owner;
  int           m_ptr;
  int           m_gid;
  logic         m_ov;
  logic         m_ol;
  logic [W-1:0] m_od;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = N - 1;
    m_gid   = 0;
    m_ov    = 1'b0;
    m_ol    = 1'b0;
    m_od    = '0;
  endtask

  task automatic push_pkt(input int r, input int nbeats, input logic [W-1:0] base);
    beat_t b;
    for (int i = 0; i < nbeats; i++) begin
      b.last = (i == nbeats - 1);
      b.data = base + W'(i);
      src_q[r].push_back(b);
    end
  endtask

  // ---------------- driver + model + checks, one clock per call ----------------
  task automatic step();
    int   sel;
    int   idx;
    logic slot;
    logic acc;
    logic [N-1:0] exp_ready;
    beat_t b;
    for (int i = 0; i < N; i++) begin
      if (src_q[i].size() > 0 && !hold[i]) begin
        in_valid[i]       = 1'b1;
        in_data[i*W +: W] = src_q[i][0].data;
        in_last[i]        = src_q[i][0].last;
      end else begin
        in_valid[i]       = 1'b0;
        in_data[i*W +: W] = W'($urandom);
        in_last[i]        = 1'($urandom_range(0, 1));
      end
    end
    #1;
    chk("out_valid", out_valid, m_ov);
    chk("out_data", out_data, m_od);
    chk("out_last", out_last, m_ol);
    chk("grant_id", grant_id, m_gid);
    chk("busy", busy, m_owner >= 0);
    if (out_valid && out_ready) begin
      chk("sb_pending", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        b = exp_q.pop_front();
        chk("sb_beat", {out_last, out_data}, b);
      end
      out_log.push_back({out_last, out_data});
    end
    slot = !m_ov || out_ready;
    sel  = -1;
    if (!rst) begin
      if (m_owner >= 0) sel = m_owner;
      else begin
        for (int k = 1; k <= N; k++) begin
          idx = (m_ptr + k) % N;
          if (sel < 0 && in_valid[idx]) sel = idx;
        end
      end
    end
    exp_ready = (sel >= 0 && slot) ? N'(1 << sel) : '0;
    chk("in_ready", in_ready, exp_ready);
    chk("in_ready_onehot", $onehot0(in_ready), 1);
    acc = (sel >= 0) && slot && in_valid[sel];
    last_ready = in_ready;
    @(posedge clk);
    for (int i = 0; i < N; i++) begin
      if (last_ready[i] && in_valid[i]) void'(src_q[i].pop_front());
    end
    if (rst) begin
      for (int i = 0; i < N; i++) src_q[i].delete();
      exp_q.delete();
      model_reset();
    end else if (acc) begin
      m_gid = sel;
      m_ov  = 1'b1;
      m_od  = in_data[sel*W +: W];
      m_ol  = in_last[sel];
      exp_q.push_back({in_last[sel], in_data[sel*W +: W]});
      if (in_last[sel]) begin
        m_owner = -1;
        m_ptr   = sel;
      end else begin
        m_owner = sel;
      end
    end else if (out_ready) begin
      m_ov = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic drain();
    logic done;
    done      = 1'b0;
    out_ready = 1'b1;
    hold      = '0;
    for (int n = 0; n < 200 && !done; n++) begin
      done = !out_valid && exp_q.size() == 0;
      for (int i = 0; i < N; i++) if (src_q[i].size() > 0) done = 1'b0;
      if (!done) step();
    end
    chk("drain_done", done, 1);
  endtask

  task automatic check_log(input string tag);
    chk({tag, "_len"}, out_log.size(), want_log.size());
    for (int i = 0; i < want_log.size() && i < out_log.size(); i++) begin
      chk(tag, out_log[i], want_log[i]);
    end
    out_log.delete();
    want_log.delete();
  endtask

  task automatic want(input logic last, input logic [W-1:0] data);
    beat_t b;
    b.last = last;
    b.data = data;
    want_log.push_back(b);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] stall_data;
    rst       = 1'b1;
    out_ready = 1'b0;
    hold      = '0;
    in_valid  = '0;
    in_last   = '0;
    in_data   = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    in_valid = '1;
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // Single-beat packets from everyone: rotation 0,1,2,3,0.
    out_ready = 1'b1;
    push_pkt(0, 1, 8'hA0);
    push_pkt(1, 1, 8'hA1);
    push_pkt(2, 1, 8'hA2);
    push_pkt(3, 1, 8'hA3);
    push_pkt(0, 1, 8'hA4);
    drain();
    want(1, 8'hA0); want(1, 8'hA1); want(1, 8'hA2); want(1, 8'hA3); want(1, 8'hA4);
    check_log("t1_rotation");

    // Two competing 3-beat packets are not interleaved.
    push_pkt(1, 3, 8'h11);
    push_pkt(2, 3, 8'h21);
    drain();
    want(0, 8'h11); want(0, 8'h12); want(1, 8'h13);
    want(0, 8'h21); want(0, 8'h22); want(1, 8'h23);
    check_log("t2_packets");

    // Downstream stall mid-packet.
    push_pkt(0, 4, 8'h31);
    step();
    step();
    stall_data = out_data;
    out_ready  = 1'b0;
    for (int n = 0; n < 3; n++) begin
      step();
      chk("t3_stall_valid", out_valid, 1);
      chk("t3_stall_data", out_data, stall_data);
      chk("t3_stall_ready", last_ready, 0);
    end
    drain();
    want(0, 8'h31); want(0, 8'h32); want(0, 8'h33); want(1, 8'h34);
    check_log("t3_backpressure");

    // Owner goes quiet mid-packet but keeps the lock.
    push_pkt(0, 4, 8'h41);
    step();
    push_pkt(3, 2, 8'h51);
    hold[0] = 1'b1;
    for (int n = 0; n < 2; n++) begin
      step();
      chk("t4_ready3", last_ready[3], 0);
      chk("t4_busy", busy, 1);
    end
    drain();
    want(0, 8'h41); want(0, 8'h42); want(0, 8'h43); want(1, 8'h44);
    want(0, 8'h51); want(1, 8'h52);
    check_log("t4_gap");

    // Reset while locked abandons the packet and restarts arbitration at 0.
    push_pkt(2, 4, 8'h61);
    step();
    step();
    chk("t5_locked", busy, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t5_out_valid", out_valid, 0);
    chk("t5_busy", busy, 0);
    chk("t5_grant_id", grant_id, 0);
    out_log.delete();
    for (int i = 0; i < N; i++) push_pkt(i, 1, 8'h70 + W'(i));
    step();
    chk("t5_first_grant", grant_id, 0);
    chk("t5_first_data", out_data, 8'h70);
    drain();
    want(1, 8'h70); want(1, 8'h71); want(1, 8'h72); want(1, 8'h73);
    check_log("t5_after_reset");

    // A lone requester streams single-beat packets back to back.
    for (int n = 0; n < 5; n++) push_pkt(3, 1, 8'h81 + W'(n));
    for (int n = 0; n < 5; n++) begin
      step();
      chk("t6_ready", last_ready, 4'b1000);
      chk("t6_grant", grant_id, 3);
      chk("t6_valid", out_valid, 1);
      chk("t6_data", out_data, 8'h81 + 32'(n));
    end
    drain();
    out_log.delete();

    // Random traffic: packets of 1-4 beats, producer gaps, downstream stalls.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        int r;
        r = $urandom_range(0, N - 1);
        if (src_q[r].size() < 8) push_pkt(r, $urandom_range(1, 4), W'($urandom));
      end
      for (int i = 0; i < N; i++) hold[i] = ($urandom_range(0, 5) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/packet_rr_mux_arbiter.md
Name: packet_rr_mux_arbiter

Overview:
- Round-robin arbiter that shares one N:1 data mux between N_REQ requesters using valid/ready handshakes.
- A requester holds its grant for a whole packet, from the first accepted beat through the beat flagged in_last.
- The selected beat is captured in a one-entry output register. Throughput is one beat per cycle and input-to-output latency is 1 cycle.
- Sits between multiple producers and one shared downstream consumer.

Parameters:
- N_REQ, 4: number of requesters; must be at least 2.
- WIDTH, 8: data width per beat.
- IDW, $clog2(N_REQ): width of grant_id (derived, not overridden).

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  N_REQ  per-requester beat valid.
- in_last  input  N_REQ  per-requester last-beat-of-packet flag.
- in_data  input  N_REQ*WIDTH  requester i occupies bits [i*WIDTH +: WIDTH].
- in_ready  output  N_REQ  per-requester accept; at most one bit is high.
- out_valid  output  1  output register holds a beat.
- out_last  output  1  last flag of the held beat.
- out_data  output  WIDTH  held beat.
- out_ready  input  1  downstream accept.
- grant_id  output  IDW  index of the current or most recent owner.
- busy  output  1  high while in LOCKED.

Behaviour:
- Reset (rst=1 at a clock edge) sets:
  - state = IDLE
  - out_valid = 0, out_last = 0, out_data = 0
  - grant_id = 0
  - priority pointer ptr = N_REQ-1, so requester 0 wins first
- in_ready is forced to all zeros combinationally while rst=1.
- Reset mid-packet abandons the packet. No recovery of the partial packet.
- Slot free: `slot = !out_valid || out_ready`.
- Accept: `acc = in_valid[g] && in_ready[g]`, where g is the selected requester.
- IDLE state:
  - Winner w is the first i with in_valid[i]=1, searching from ptr+1 upward and wrapping modulo N_REQ. The search is combinational.
  - in_ready[w] = slot; all other in_ready bits are 0.
  - No in_valid high: all in_ready are 0 and the state is held.
  - On acc: grant_id <= w.
  - If in_last[w]=1 (single-beat packet): stay in IDLE and set ptr <= w.
  - Otherwise: go to LOCKED.
- LOCKED state:
  - g = grant_id. in_ready[grant_id] = slot; all other in_ready bits are 0, even if those requesters are valid.
  - A granted requester that drops in_valid mid-packet keeps the lock. Other requesters stall indefinitely.
  - On acc with in_last[g]=1: go to IDLE and set ptr <= grant_id.
  - busy = 1 only in LOCKED.
- Output register:
  - On acc: out_valid <= 1, out_data <= in_data[g], out_last <= in_last[g].
  - Else if out_ready: out_valid <= 0. out_data and out_last keep their values.
  - Simultaneous pop and accept in the same cycle: the new beat replaces the old one and out_valid stays 1. No bubble.
  - out_valid=1 and out_ready=0: slot=0, no accept occurs, and out_data stays stable.
- Fairness:
  - After a packet from requester k completes, k has the lowest priority in the next arbitration.
  - Pointer wrap goes from N_REQ-1 to 0.
  - Starvation bound: one packet from each other requester.
- in_valid or in_data changes while in_ready=0 have no effect.

Test Plan:
- Reset, then drive in_valid=4'b1111 with all in_last=1 and out_ready=1. Required: grants 0,1,2,3,0 on consecutive cycles; out_data follows with 1-cycle latency; in_ready is one-hot every cycle.
- Requesters 1 and 2 each send a 3-beat packet (data 0x11,0x12,0x13 / 0x21,0x22,0x23), both valid from the start, out_ready=1. Required:
  - out_data sequence is 0x11,0x12,0x13,0x21,0x22,0x23.
  - out_last is high on 0x13 and 0x23.
  - in_ready[2] stays 0 until the 0x13 beat is accepted.
  - busy is high during each packet.
- Backpressure: hold out_ready=0 for 3 cycles mid-packet. Required: out_valid=1, out_data stable, in_ready all 0 during the stall; no beat lost or duplicated after release.
- Granted requester 0 drops in_valid for 2 cycles mid-packet while requester 3 is valid. Required: in_ready[3] stays 0, busy=1, and requester 0 finishes its packet before requester 3 is granted.
- Assert rst in LOCKED mid-packet. Required: next cycle out_valid=0, busy=0, grant_id=0; with all requesters valid, requester 0 wins the first arbitration.
- Only requester 3 valid, out_ready=1, 5 single-beat packets. Required: accepted back-to-back every cycle and grant_id=3 throughout.
